// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: multi-channel Avalon-MM front-end for the single DDR3 port.
// Round-robin command arbitration with write-burst grant locking, and an
// in-order tag FIFO that steers each returning read beat to its channel.
module ddr_port_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_address,
    input  logic [NUM_CH-1:0]            ch_read,
    input  logic [NUM_CH-1:0]            ch_write,
    input  logic [NUM_CH*DATA_W-1:0]     ch_writedata,
    input  logic [NUM_CH*DATA_W/8-1:0]   ch_byteenable,
    input  logic [NUM_CH*BURST_W-1:0]    ch_burstcount,
    output logic [NUM_CH-1:0]            ch_waitrequest,
    output logic [DATA_W-1:0]            ch_readdata,
    output logic [NUM_CH-1:0]            ch_readdatavalid,
    output logic [ADDR_W-1:0]            m_address,
    output logic                         m_read,
    output logic                         m_write,
    output logic [DATA_W-1:0]            m_writedata,
    output logic [DATA_W/8-1:0]          m_byteenable,
    output logic [BURST_W-1:0]           m_burstcount,
    input  logic                         m_waitrequest,
    input  logic [DATA_W-1:0]            m_readdata,
    input  logic                         m_readdatavalid,
    output logic                         rsp_error
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {
        IDLE,
        WR_BURST
    } arbState_t;

    arbState_t             r_state;
    arbState_t             w_nextState;

    logic [CH_W-1:0]       r_rrPtr;
    logic [CH_W-1:0]       r_lockCh;
    logic [BURST_W-1:0]    r_remaining;

    logic [CH_W-1:0]       r_tagCh  [TAG_DEPTH];
    logic [BURST_W-1:0]    r_tagLen [TAG_DEPTH];
    logic [TAG_AW-1:0]     r_wrPtr;
    logic [TAG_AW-1:0]     r_rdPtr;
    logic [TAG_AW:0]       r_count;
    logic [BURST_W-1:0]    r_rdBeat;
    logic                  r_rspError;

    logic [NUM_CH-1:0]     w_req;
    logic [CH_W-1:0]       w_grant;
    logic                  w_anyReq;
    logic [CH_W-1:0]       w_selCh;
    logic                  w_selRead;
    logic                  w_selWrite;
    logic [ADDR_W-1:0]     w_selAddr;
    logic [DATA_W-1:0]     w_selData;
    logic [BE_W-1:0]       w_selBe;
    logic [BURST_W-1:0]    w_selBc;
    logic [BURST_W-1:0]    w_selBcEff;
    logic                  w_tagFull;
    logic                  w_tagEmpty;
    logic [CH_W-1:0]       w_headCh;
    logic [BURST_W-1:0]    w_headLen;
    logic                  w_rdAcc;
    logic                  w_wrAcc;
    logic                  w_push;
    logic                  w_pop;

    function automatic logic [CH_W-1:0] nextCh(input logic [CH_W-1:0] c);
        if (c == CH_W'(NUM_CH - 1)) begin
            return '0;
        end
        return c + CH_W'(1);
    endfunction

    assign w_req      = ch_read | ch_write;
    assign w_tagFull  = (r_count == (TAG_AW+1)'(TAG_DEPTH));
    assign w_tagEmpty = (r_count == '0);
    assign w_headCh   = r_tagCh[r_rdPtr];
    assign w_headLen  = r_tagLen[r_rdPtr];
    assign w_rdAcc    = m_read & ~m_waitrequest;
    assign w_wrAcc    = m_write & ~m_waitrequest;
    assign w_push     = w_rdAcc;
    assign w_pop      = m_readdatavalid & ~w_tagEmpty & ((r_rdBeat + BURST_W'(1)) == w_headLen);
    assign ch_readdata = m_readdata;
    assign rsp_error   = r_rspError;

    // Round-robin search: first requester at or above the pointer, wrapping
    always_comb begin
        int idx;
        idx      = 0;
        w_grant  = '0;
        w_anyReq = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(r_rrPtr) + k) % NUM_CH;
            if (!w_anyReq && w_req[idx]) begin
                w_anyReq = 1'b1;
                w_grant  = CH_W'(idx);
            end
        end
    end

    // Pick the channel driving the memory port: locked channel during a burst
    always_comb begin
        w_selCh    = (r_state == WR_BURST) ? r_lockCh : w_grant;
        w_selRead  = 1'b0;
        w_selWrite = 1'b0;
        w_selAddr  = '0;
        w_selData  = '0;
        w_selBe    = '0;
        w_selBc    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == w_selCh) begin
                w_selRead  = ch_read[i];
                w_selWrite = ch_write[i];
                w_selAddr  = ch_address[i*ADDR_W +: ADDR_W];
                w_selData  = ch_writedata[i*DATA_W +: DATA_W];
                w_selBe    = ch_byteenable[i*BE_W +: BE_W];
                w_selBc    = ch_burstcount[i*BURST_W +: BURST_W];
            end
        end
        w_selBcEff = (w_selBc == '0) ? BURST_W'(1) : w_selBc;
    end

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: enter a burst on a multi-beat write, leave on its last beat
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_wrAcc && (w_selBcEff > BURST_W'(1))) begin
                    w_nextState = WR_BURST;
                end
            end
            WR_BURST: begin
                if (w_wrAcc && (r_remaining == BURST_W'(1))) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Command outputs; during a burst a read from the locked channel stays stalled so it is never falsely accepted
    always_comb begin
        m_address      = w_selAddr;
        m_writedata    = w_selData;
        m_byteenable   = w_selBe;
        m_burstcount   = w_selBc;
        m_read         = 1'b0;
        m_write        = 1'b0;
        ch_waitrequest = '1;
        if (reset_reset_n) begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        m_read  = w_selRead & ~w_tagFull;
                        m_write = w_selWrite & ~w_selRead;
                        ch_waitrequest[w_selCh] = m_waitrequest | (w_selRead & w_tagFull);
                    end
                end
                WR_BURST: begin
                    m_write = w_selWrite;
                    ch_waitrequest[w_selCh] = m_waitrequest | ~w_selWrite;
                end
                default: ;
            endcase
        end
    end

    // Round-robin pointer, burst lock channel and remaining-beat counter
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rrPtr     <= '0;
            r_lockCh    <= '0;
            r_remaining <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (w_rdAcc) begin
                    r_rrPtr <= nextCh(w_grant);
                end else if (w_wrAcc) begin
                    if (w_selBcEff > BURST_W'(1)) begin
                        r_lockCh    <= w_grant;
                        r_remaining <= w_selBcEff - BURST_W'(1);
                    end else begin
                        r_rrPtr <= nextCh(w_grant);
                    end
                end
            end else if (w_wrAcc) begin
                r_remaining <= r_remaining - BURST_W'(1);
                if (r_remaining == BURST_W'(1)) begin
                    r_rrPtr <= nextCh(r_lockCh);
                end
            end
        end
    end

    // Tag FIFO pointers, occupancy, read-beat counter and sticky orphan flag
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_rdBeat   <= '0;
            r_rspError <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + TAG_AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + TAG_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (TAG_AW+1)'(1);
                2'b01:   r_count <= r_count - (TAG_AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (m_readdatavalid && !w_tagEmpty) begin
                r_rdBeat <= w_pop ? '0 : (r_rdBeat + BURST_W'(1));
            end
            if (m_readdatavalid && w_tagEmpty) begin
                r_rspError <= 1'b1;
            end
        end
    end

    // Tag storage: issuing channel and effective burst length of each read
    always_ff @(posedge clk_clk) begin
        if (w_push) begin
            r_tagCh[r_wrPtr]  <= w_selCh;
            r_tagLen[r_wrPtr] <= w_selBcEff;
        end
    end

    // Steer the returning beat to the channel at the head of the tag FIFO
    always_comb begin
        ch_readdatavalid = '0;
        if (reset_reset_n && m_readdatavalid && !w_tagEmpty) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (CH_W'(i) == w_headCh) begin
                    ch_readdatavalid[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: directed vectors for ddr_port_arbiter with hand-computed
// expectations for arbitration order, burst locking, tag FIFO and read routing.
module tb_ddr_port_arbiter;

    localparam int NUM_CH    = 2;
    localparam int ADDR_W    = 29;
    localparam int DATA_W    = 32;
    localparam int BURST_W   = 4;
    localparam int TAG_DEPTH = 8;
    localparam int BE_W      = DATA_W / 8;

    logic                        clk = 1'b0;
    logic                        rstN;
    logic [NUM_CH*ADDR_W-1:0]    chAddress;
    logic [NUM_CH-1:0]           chRead;
    logic [NUM_CH-1:0]           chWrite;
    logic [NUM_CH*DATA_W-1:0]    chWritedata;
    logic [NUM_CH*BE_W-1:0]      chByteenable;
    logic [NUM_CH*BURST_W-1:0]   chBurstcount;
    logic [NUM_CH-1:0]           chWait;
    logic [DATA_W-1:0]           chReaddata;
    logic [NUM_CH-1:0]           chRdv;
    logic [ADDR_W-1:0]           mAddress;
    logic                        mRead;
    logic                        mWrite;
    logic [DATA_W-1:0]           mWritedata;
    logic [BE_W-1:0]             mByteenable;
    logic [BURST_W-1:0]          mBurstcount;
    logic                        mWaitrequest;
    logic [DATA_W-1:0]           mReaddata;
    logic                        mRdv;
    logic                        rspError;

    int totalChecks = 0;
    int badChecks   = 0;

    // 100 MHz clock
    always #5 clk = ~clk;

    ddr_port_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BURST_W(BURST_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rstN),
        .ch_address(chAddress),
        .ch_read(chRead),
        .ch_write(chWrite),
        .ch_writedata(chWritedata),
        .ch_byteenable(chByteenable),
        .ch_burstcount(chBurstcount),
        .ch_waitrequest(chWait),
        .ch_readdata(chReaddata),
        .ch_readdatavalid(chRdv),
        .m_address(mAddress),
        .m_read(mRead),
        .m_write(mWrite),
        .m_writedata(mWritedata),
        .m_byteenable(mByteenable),
        .m_burstcount(mBurstcount),
        .m_waitrequest(mWaitrequest),
        .m_readdata(mReaddata),
        .m_readdatavalid(mRdv),
        .rsp_error(rspError)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic rd, input logic wr,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                 input logic [BURST_W-1:0] bc);
        chRead[ch]                             = rd;
        chWrite[ch]                            = wr;
        chAddress[ch*ADDR_W +: ADDR_W]         = addr;
        chWritedata[ch*DATA_W +: DATA_W]       = data;
        chByteenable[ch*BE_W +: BE_W]          = '1;
        chBurstcount[ch*BURST_W +: BURST_W]    = bc;
    endtask

    task automatic clearStimulus();
        chRead       = '0;
        chWrite      = '0;
        chAddress    = '0;
        chWritedata  = '0;
        chByteenable = '0;
        chBurstcount = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN         = 1'b0;
        mWaitrequest = 1'b0;
        mReaddata    = '0;
        mRdv         = 1'b0;
        clearStimulus();

        // Reset state
        #3;
        checkOutput("rst_wait", chWait, 2'b11);
        checkOutput("rst_mread", mRead, 0);
        checkOutput("rst_mwrite", mWrite, 0);
        checkOutput("rst_rsperr", rspError, 0);
        checkOutput("rst_rdv", chRdv, 0);
        @(posedge clk);
        nextCycle();
        rstN = 1'b1;

        // Idle with no requests
        #3;
        checkOutput("idle_wait", chWait, 2'b11);
        checkOutput("idle_mread", mRead, 0);
        nextCycle();

        // Both channels read continuously: grants alternate 0,1,0,1
        applyStimulus(0, 1'b1, 1'b0, 29'h100, '0, 4'd1);
        applyStimulus(1, 1'b1, 1'b0, 29'h200, '0, 4'd1);
        for (int k = 0; k < 4; k++) begin
            #3;
            checkOutput("rr_mread", mRead, 1);
            checkOutput("rr_addr", mAddress, (k % 2 == 0) ? 64'h100 : 64'h200);
            checkOutput("rr_wait", chWait, (k % 2 == 0) ? 64'b10 : 64'b01);
            nextCycle();
        end
        clearStimulus();
        for (int k = 0; k < 4; k++) begin
            mRdv      = 1'b1;
            mReaddata = 32'hD000 + k;
            #3;
            checkOutput("rr_rdv", chRdv, (k % 2 == 0) ? 64'b01 : 64'b10);
            checkOutput("rr_rdata", chReaddata, 64'hD000 + k);
            checkOutput("rr_idle_mread", mRead, 0);
            nextCycle();
        end
        mRdv = 1'b0;

        // Single write with burstcount 0 completes in one beat, pointer moves to ch1
        applyStimulus(0, 1'b0, 1'b1, 29'h300, 32'hAAAA, 4'd0);
        #3;
        checkOutput("w0_mwrite", mWrite, 1);
        checkOutput("w0_wdata", mWritedata, 64'hAAAA);
        checkOutput("w0_wait", chWait, 2'b10);
        nextCycle();
        clearStimulus();

        // ch1 burst of 4 while ch0 reads; one memory stall mid-burst
        applyStimulus(0, 1'b1, 1'b0, 29'h310, '0, 4'd1);
        applyStimulus(1, 1'b0, 1'b1, 29'h400, 32'hB1, 4'd4);
        #3;
        checkOutput("wb1_mwrite", mWrite, 1);
        checkOutput("wb1_mread", mRead, 0);
        checkOutput("wb1_wait", chWait, 2'b01);
        checkOutput("wb1_bc", mBurstcount, 4);
        checkOutput("wb1_addr", mAddress, 64'h400);
        nextCycle();
        mWaitrequest = 1'b1;
        #3;
        checkOutput("wb_stall_wait", chWait, 2'b11);
        checkOutput("wb_stall_mwrite", mWrite, 1);
        nextCycle();
        mWaitrequest = 1'b0;
        for (int b = 2; b <= 4; b++) begin
            applyStimulus(1, 1'b0, 1'b1, 29'h400, 32'hB0 + b, 4'd4);
            #3;
            checkOutput("wb_beat_wait", chWait, 2'b01);
            checkOutput("wb_beat_mread", mRead, 0);
            checkOutput("wb_beat_wdata", mWritedata, 64'hB0 + b);
            checkOutput("wb_beat_bc", mBurstcount, 4);
            nextCycle();
        end
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        #3;
        checkOutput("wb_after_mread", mRead, 1);
        checkOutput("wb_after_wait", chWait, 2'b10);
        checkOutput("wb_after_addr", mAddress, 64'h310);
        checkOutput("wb_after_mwrite", mWrite, 0);
        nextCycle();
        clearStimulus();
        mRdv      = 1'b1;
        mReaddata = 32'hE1;
        #3;
        checkOutput("wb_rd_rdv", chRdv, 2'b01);
        nextCycle();
        mRdv = 1'b0;

        // Fill the tag FIFO with 8 reads, then the 9th is blocked
        applyStimulus(0, 1'b1, 1'b0, 29'h600, '0, 4'd1);
        for (int k = 0; k < TAG_DEPTH; k++) begin
            #3;
            checkOutput("fill_wait", chWait, 2'b10);
            nextCycle();
        end
        #3;
        checkOutput("full_wait", chWait, 2'b11);
        checkOutput("full_mread", mRead, 0);
        nextCycle();
        mRdv = 1'b1;
        #3;
        checkOutput("full_pop_wait", chWait, 2'b11);
        checkOutput("full_pop_rdv", chRdv, 2'b01);
        nextCycle();
        mRdv = 1'b0;
        #3;
        checkOutput("ninth_mread", mRead, 1);
        checkOutput("ninth_wait", chWait, 2'b10);
        nextCycle();
        clearStimulus();
        for (int k = 0; k < TAG_DEPTH; k++) begin
            mRdv = 1'b1;
            #3;
            checkOutput("drain_rdv", chRdv, 2'b01);
            nextCycle();
        end
        mRdv = 1'b0;

        // Read burst of 3 from ch1, then a single read from ch0
        applyStimulus(1, 1'b1, 1'b0, 29'h700, '0, 4'd3);
        #3;
        checkOutput("rb_mread", mRead, 1);
        checkOutput("rb_bc", mBurstcount, 3);
        checkOutput("rb_wait", chWait, 2'b01);
        nextCycle();
        clearStimulus();
        applyStimulus(0, 1'b1, 1'b0, 29'h710, '0, 4'd1);
        #3;
        checkOutput("rs_wait", chWait, 2'b10);
        checkOutput("rs_bc", mBurstcount, 1);
        nextCycle();
        clearStimulus();
        for (int k = 0; k < 4; k++) begin
            mRdv = 1'b1;
            #3;
            checkOutput("rb_rdv", chRdv, (k < 3) ? 64'b10 : 64'b01);
            nextCycle();
        end
        mRdv = 1'b0;

        // Orphan read data with the FIFO empty
        mRdv = 1'b1;
        #3;
        checkOutput("orph_rdv", chRdv, 0);
        checkOutput("orph_err_before", rspError, 0);
        nextCycle();
        mRdv = 1'b0;
        #3;
        checkOutput("orph_err_set", rspError, 1);
        nextCycle();
        #3;
        checkOutput("orph_err_sticky", rspError, 1);
        nextCycle();

        // Reset in the middle of a write burst
        applyStimulus(1, 1'b0, 1'b1, 29'h800, 32'hC0, 4'd4);
        #3;
        checkOutput("rb4_mwrite", mWrite, 1);
        checkOutput("rb4_wait", chWait, 2'b01);
        nextCycle();
        nextCycle();
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_wait", chWait, 2'b11);
        checkOutput("mid_rst_mwrite", mWrite, 0);
        checkOutput("mid_rst_err", rspError, 0);
        nextCycle();
        rstN = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 29'h900, '0, 4'd1);
        #3;
        checkOutput("post_rst_mread", mRead, 1);
        checkOutput("post_rst_mwrite", mWrite, 0);
        checkOutput("post_rst_wait", chWait, 2'b10);
        checkOutput("post_rst_addr", mAddress, 64'h900);
        checkOutput("post_rst_err", rspError, 0);
        nextCycle();
        clearStimulus();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Parametrised multi-channel Avalon-MM front-end placed between NUM_CH fabric masters and the single HPS DDR3 SDRAM port of the system.
- Arbitrates read and write commands round-robin.
- Locks the grant for the full length of a write burst.
- Tracks outstanding reads in an in-order tag FIFO so each read-data beat is routed back to the channel that issued it.
- Generalises the current single-master memory attachment to N channels with burst support.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8).
- ADDR_W, 29, word address width.
- DATA_W, 32, data width (multiple of 8).
- BURST_W, 4, burstcount width (max burst 2^(BURST_W-1) beats).
- TAG_DEPTH, 8, outstanding read commands held (power of 2).

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- ch_address  in  NUM_CH*ADDR_W  per-channel address, channel i at slice i
- ch_read  in  NUM_CH  per-channel read request
- ch_write  in  NUM_CH  per-channel write request
- ch_writedata  in  NUM_CH*DATA_W  per-channel write data
- ch_byteenable  in  NUM_CH*DATA_W/8  per-channel byte enables
- ch_burstcount  in  NUM_CH*BURST_W  per-channel burst length
- ch_waitrequest  out  NUM_CH  per-channel stall
- ch_readdata  out  DATA_W  read data, shared by all channels
- ch_readdatavalid  out  NUM_CH  one-hot read-data valid
- m_address  out  ADDR_W  to memory port
- m_read  out  1  to memory port
- m_write  out  1  to memory port
- m_writedata  out  DATA_W  to memory port
- m_byteenable  out  DATA_W/8  to memory port
- m_burstcount  out  BURST_W  to memory port
- m_waitrequest  in  1  memory stall
- m_readdata  in  DATA_W  memory read data
- m_readdatavalid  in  1  memory read-data valid
- rsp_error  out  1  sticky: readdatavalid arrived with the tag FIFO empty

Behaviour:
- Reset (asynchronous, any time):
  - state=IDLE, rr_ptr=0, tag FIFO empty, beat counters 0, rsp_error=0.
  - m_read=m_write=0, ch_readdatavalid=0, ch_waitrequest all 1.
  - An in-flight burst is abandoned and is not resumed after reset.
- Request: req[i]=ch_read[i]|ch_write[i]. ch_read[i] and ch_write[i] asserted together is illegal; read wins.
- IDLE:
  - grant g = first requesting channel scanning from rr_ptr upward, wrapping at NUM_CH.
  - Combinational, zero-latency pass-through: the m_* command signals mux from channel g.
  - m_read = ch_read[g] & !tag_full.
  - ch_waitrequest[g] = m_waitrequest | (ch_read[g] & tag_full).
  - All other ch_waitrequest bits are 1. With no request, all bits are 1 and m_read=m_write=0.
- Accepted read (m_read & !m_waitrequest):
  - push {g, burstcount} into the tag FIFO.
  - rr_ptr <= (g+1) mod NUM_CH.
- Accepted write beat:
  - If burstcount<=1, the write completes: rr_ptr <= g+1.
  - Otherwise: lock_ch<=g, remaining<=burstcount-1, go to WR_BURST.
  - burstcount=0 is treated as 1 everywhere, for reads and writes.
- WR_BURST:
  - Only lock_ch is muxed and unstalled. Other requests wait.
  - m_burstcount is still passed through from lock_ch.
  - Each accepted beat decrements remaining. On the beat with remaining==1: return to IDLE, rr_ptr <= lock_ch+1.
  - Reads from lock_ch are ignored until the burst ends.
- Read return:
  - ch_readdata = m_readdata, combinational.
  - ch_readdatavalid = onehot(head.ch) & m_readdatavalid when FIFO non-empty.
  - rd_beat counts beats. When rd_beat+1 == head.burstcount: pop the head and clear rd_beat.
- Tag FIFO:
  - tag_full uses the registered count only. No bypass: a push is blocked when full even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
  - Pointers wrap modulo TAG_DEPTH.
- Orphan response: m_readdatavalid with the FIFO empty is dropped, rsp_error<=1, and rsp_error holds until reset.
- Throughput: one command accepted per cycle maximum. Read data is forwarded with zero added latency.

Test Plan:
- Reset then idle: all ch_waitrequest=1, m_read=m_write=0, rsp_error=0.
- ch0 and ch1 both request single reads continuously with m_waitrequest=0:
  - grants alternate 0,1,0,1.
  - 4 readdatavalid beats route to ch0,ch1,ch0,ch1 in order.
- ch1 write burst of 4 while ch0 requests a read:
  - ch0 is stalled for exactly 4 accepted beats.
  - ch0 is granted on the following cycle.
  - m_waitrequest stall inserted mid-burst: 4 beats still complete.
- Fill the tag FIFO (8 reads, no data returned):
  - 9th read sees ch_waitrequest=1 and m_read=0.
  - After one read-data beat pops the head, the 9th read is accepted.
- Read burst of 3 from ch1 then single read from ch0: 3 beats flag ch1, then 1 beat flags ch0.
- m_readdatavalid with the FIFO empty: no ch_readdatavalid, rsp_error=1 and sticky. Reset asserted mid-write-burst returns to IDLE and clears rsp_error.
